// File: rtl/store_buffer.sv
// FIFO of pending core stores retired to data memory one per load-free cycle; loads overlapping a pending store stall.
// Store-to-write latency >= 1 cycle (no empty bypass); st_ready depends only on the registered count.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_snb,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [1:0]        ld_snb,
  input  logic              ld_uns,
  output logic              ld_stall,
  output logic [31:0]       ld_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  output logic [1:0]        mem_snb,
  input  logic [31:0]       mem_rd,
  output logic              empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [1:0]        snb;
  } entry_t;

  function automatic logic [2:0] nbytes(input logic [1:0] snb);
    case (snb)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      2'b10:   nbytes = 3'd4;
      default: nbytes = 3'd0;
    endcase
  endfunction

  entry_t          ent_q [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic            enq;
  logic            drain;
  logic [DEPTH-1:0] ovl;
  logic [ADDR_W:0] ld_lo;
  logic [ADDR_W:0] ld_hi;

  assign st_ready = (count < CW'(DEPTH));
  assign empty    = (count == '0);
  assign enq      = st_valid & st_ready & ~rst;
  assign head     = ent_q[rptr];

  // Range compare carried in ADDR_W+1 bits so an access at the top of memory never wraps.
  assign ld_lo = {1'b0, ld_addr};
  assign ld_hi = ld_lo + {{(ADDR_W-2){1'b0}}, nbytes(ld_snb)};

  for (genvar i = 0; i < DEPTH; i++) begin : g_ovl
    logic [PW-1:0]   ofs;
    logic [2:0]      e_n;
    logic [ADDR_W:0] e_lo;
    logic [ADDR_W:0] e_hi;
    assign ofs  = PW'(i) - rptr;
    assign e_n  = nbytes(ent_q[i].snb);
    assign e_lo = {1'b0, ent_q[i].addr};
    assign e_hi = e_lo + {{(ADDR_W-2){1'b0}}, e_n};
    assign ovl[i] = ({1'b0, ofs} < count) && (e_n != 3'd0) && (ld_lo < e_hi) && (e_lo < ld_hi);
  end

  assign ld_stall = ld_req & ~rst & (|ovl);
  assign drain    = (count != '0) & (~ld_req | ld_stall) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (enq)   wptr <= wptr + 1'b1;
      if (drain) rptr <= rptr + 1'b1;
      count <= count + CW'(enq) - CW'(drain);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) ent_q[wptr] <= '{addr: st_addr, data: st_data, snb: st_snb};
  end

  always_comb begin
    mem_we  = drain;
    mem_a   = '0;
    mem_wd  = '0;
    mem_snb = 2'b00;
    if (drain) begin
      mem_a   = head.addr;
      mem_wd  = head.data;
      mem_snb = head.snb;
    end else if (ld_req) begin
      mem_a   = ld_addr;
      mem_snb = ld_snb;
    end
  end

  always_comb begin
    case (ld_snb)
      2'b00:   ld_data = {{24{~ld_uns & mem_rd[7]}}, mem_rd[7:0]};
      2'b01:   ld_data = {{16{~ld_uns & mem_rd[15]}}, mem_rd[15:0]};
      2'b10:   ld_data = mem_rd;
      default: ld_data = '0;
    endcase
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a 256-byte memory model on the mem_* side.
module tb_store_buffer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic [1:0]        st_snb;
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [1:0]        ld_snb;
  logic              ld_uns;
  logic              ld_stall;
  logic [31:0]       ld_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [31:0]       mem_wd;
  logic [1:0]        mem_snb;
  logic [31:0]       mem_rd;
  logic              empty;

  int errs = 0;
  int checks = 0;
  int wr_cnt = 0;
  int base;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_snb(st_snb),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_snb(ld_snb), .ld_uns(ld_uns),
    .ld_stall(ld_stall), .ld_data(ld_data),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_snb(mem_snb), .mem_rd(mem_rd),
    .empty(empty)
  );

  logic [7:0] mem [0:255] = '{default: 8'h00};
  logic [7:0] wa;
  assign wa     = mem_a[7:0];
  assign mem_rd = {mem[wa + 8'd3], mem[wa + 8'd2], mem[wa + 8'd1], mem[wa]};

  always @(posedge clk) begin
    if (mem_we) begin
      wr_cnt <= wr_cnt + 1;
      if (mem_snb != 2'b11) mem[wa] <= mem_wd[7:0];
      if (mem_snb == 2'b01 || mem_snb == 2'b10) mem[wa + 8'd1] <= mem_wd[15:8];
      if (mem_snb == 2'b10) begin
        mem[wa + 8'd2] <= mem_wd[23:16];
        mem[wa + 8'd3] <= mem_wd[31:24];
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    tick();
    st_valid = 1'b1; st_addr = a; st_data = d; st_snb = s;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic drain_out;
    for (int n = 0; n < 20 && !empty; n++) tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++; if (empty !== 1'b1)    begin errs++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (st_ready !== 1'b1) begin errs++; $display("FAIL reset_st_ready: got %b want 1", st_ready); end
    checks++; if (mem_we !== 1'b0)   begin errs++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (ld_stall !== 1'b0) begin errs++; $display("FAIL reset_ld_stall: got %b want 0", ld_stall); end
    checks++; if (wr_cnt != 0)       begin errs++; $display("FAIL reset_writes: got %0d want 0", wr_cnt); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_store_word;
    tick();
    st_valid = 1'b1; st_addr = 32'h10; st_data = 32'hDEADBEEF; st_snb = 2'b10;
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin errs++; $display("FAIL sw_no_bypass: mem_we got %b want 0", mem_we); end
    tick();
    st_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_we !== 1'b1)         begin errs++; $display("FAIL sw_we: got %b want 1", mem_we); end
    checks++; if (mem_a !== 32'h10)        begin errs++; $display("FAIL sw_addr: got %h want 10", mem_a); end
    checks++; if (mem_snb !== 2'b10)       begin errs++; $display("FAIL sw_snb: got %b want 10", mem_snb); end
    checks++; if (mem_wd !== 32'hDEADBEEF) begin errs++; $display("FAIL sw_wd: got %h want deadbeef", mem_wd); end
    checks++; if (empty !== 1'b0)          begin errs++; $display("FAIL sw_pending: empty got %b want 0", empty); end
    tick();
    @(negedge clk);
    checks++; if (empty !== 1'b1) begin errs++; $display("FAIL sw_empty_after: got %b want 1", empty); end
    checks++; if ({mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} !== 32'hDEADBEEF)
      begin errs++; $display("FAIL sw_mem_bytes: got %h%h%h%h want deadbeef", mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]); end
  endtask

  task automatic test_fill;
    tick();
    ld_req = 1'b1; ld_addr = 32'h80; ld_snb = 2'b10; ld_uns = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      st_valid = 1'b1; st_addr = 32'h30 + 32'(4 * i); st_data = 32'h11111111 * 32'(i + 1); st_snb = 2'b10;
      @(negedge clk);
      checks++; if (st_ready !== 1'b1) begin errs++; $display("FAIL fill_ready_%0d: got %b want 1", i, st_ready); end
      checks++; if (mem_we !== 1'b0)   begin errs++; $display("FAIL fill_hold_%0d: mem_we got %b want 0", i, mem_we); end
      tick();
    end
    st_addr = 32'h60; st_data = 32'hCAFEF00D;
    @(negedge clk);
    checks++; if (st_ready !== 1'b0) begin errs++; $display("FAIL full_ready: got %b want 0", st_ready); end
    checks++; if (mem_we !== 1'b0)   begin errs++; $display("FAIL full_we: got %b want 0", mem_we); end
    checks++; if (ld_stall !== 1'b0) begin errs++; $display("FAIL full_no_stall: got %b want 0", ld_stall); end
    checks++; if (ld_data !== 32'h0) begin errs++; $display("FAIL full_ld_data: got %h want 0", ld_data); end
    tick();
    st_valid = 1'b0; ld_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      checks++; if (mem_we !== 1'b1 || mem_a !== 32'h30 + 32'(4 * i) || mem_wd !== 32'h11111111 * 32'(i + 1))
        begin errs++; $display("FAIL fill_drain_%0d: got we=%b a=%h wd=%h", i, mem_we, mem_a, mem_wd); end
      tick();
    end
    @(negedge clk);
    checks++; if (empty !== 1'b1 || st_ready !== 1'b1 || mem_we !== 1'b0)
      begin errs++; $display("FAIL fill_done: got empty=%b ready=%b we=%b want 1 1 0", empty, st_ready, mem_we); end
    checks++; if (mem[8'h60] !== 8'h00) begin errs++; $display("FAIL fill_rejected_store: mem[60] got %h want 00", mem[8'h60]); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      tick();
      st_valid = (i < 3); st_addr = 32'h90 + 32'(4 * i); st_data = 32'hA0A0A0A0 + 32'(i); st_snb = 2'b10;
      @(negedge clk);
      if (i == 0) begin
        checks++; if (mem_we !== 1'b0) begin errs++; $display("FAIL b2b_first: mem_we got %b want 0", mem_we); end
      end else begin
        checks++; if (mem_we !== 1'b1 || mem_a !== 32'h90 + 32'(4 * (i - 1)) || empty !== 1'b0)
          begin errs++; $display("FAIL b2b_drain_%0d: got we=%b a=%h empty=%b", i, mem_we, mem_a, empty); end
      end
    end
    tick();
    st_valid = 1'b0;
    @(negedge clk);
    checks++; if (empty !== 1'b1) begin errs++; $display("FAIL b2b_empty: got %b want 1", empty); end
    checks++; if ({mem[8'h9B], mem[8'h9A], mem[8'h99], mem[8'h98]} !== 32'hA0A0A0A2)
      begin errs++; $display("FAIL b2b_last_word: got %h%h%h%h want a0a0a0a2", mem[8'h9B], mem[8'h9A], mem[8'h99], mem[8'h98]); end
  endtask

  task automatic test_overlap;
    tick();
    ld_req = 1'b1; ld_addr = 32'h80; ld_snb = 2'b10; ld_uns = 1'b0;
    st_valid = 1'b1; st_addr = 32'h21; st_data = 32'h0000005A; st_snb = 2'b00;
    @(negedge clk);
    checks++; if (ld_stall !== 1'b0 || mem_we !== 1'b0)
      begin errs++; $display("FAIL ovl_enqueue: got stall=%b we=%b want 0 0", ld_stall, mem_we); end
    tick();
    st_valid = 1'b0; ld_addr = 32'h20;
    @(negedge clk);
    checks++; if (ld_stall !== 1'b1) begin errs++; $display("FAIL ovl_stall: got %b want 1", ld_stall); end
    checks++; if (mem_we !== 1'b1 || mem_a !== 32'h21 || mem_snb !== 2'b00)
      begin errs++; $display("FAIL ovl_drain: got we=%b a=%h snb=%b want 1 21 00", mem_we, mem_a, mem_snb); end
    tick();
    @(negedge clk);
    checks++; if (ld_stall !== 1'b0 || mem_we !== 1'b0 || mem_a !== 32'h20)
      begin errs++; $display("FAIL ovl_release: got stall=%b we=%b a=%h want 0 0 20", ld_stall, mem_we, mem_a); end
    checks++; if (ld_data !== 32'h00005A00) begin errs++; $display("FAIL ovl_data: got %h want 00005a00", ld_data); end
  endtask

  task automatic test_boundary;
    tick();
    ld_req = 1'b1; ld_addr = 32'h80; ld_snb = 2'b10; ld_uns = 1'b0;
    st_valid = 1'b1; st_addr = 32'h20; st_data = 32'h01020304; st_snb = 2'b10;
    tick();
    st_valid = 1'b0; ld_addr = 32'h1C;
    @(negedge clk);
    checks++; if (ld_stall !== 1'b0 || mem_we !== 1'b0)
      begin errs++; $display("FAIL bnd_below: got stall=%b we=%b want 0 0", ld_stall, mem_we); end
    ld_addr = 32'h24;
    #1;
    checks++; if (ld_stall !== 1'b0) begin errs++; $display("FAIL bnd_above: got %b want 0", ld_stall); end
    ld_addr = 32'h20; ld_snb = 2'b11;
    #1;
    checks++; if (ld_stall !== 1'b0 || ld_data !== 32'h0)
      begin errs++; $display("FAIL bnd_noop_load: got stall=%b data=%h want 0 0", ld_stall, ld_data); end
    ld_addr = 32'h23; ld_snb = 2'b00;
    #1;
    checks++; if (ld_stall !== 1'b1) begin errs++; $display("FAIL bnd_last_byte: got %b want 1", ld_stall); end
    tick();
    @(negedge clk);
    checks++; if (ld_stall !== 1'b0 || ld_data !== 32'h00000001)
      begin errs++; $display("FAIL bnd_after: got stall=%b data=%h want 0 00000001", ld_stall, ld_data); end
    ld_req = 1'b0;
  endtask

  task automatic test_extend;
    store(32'h40, 32'h00000080, 2'b00);
    drain_out();
    tick();
    ld_req = 1'b1; ld_addr = 32'h40; ld_snb = 2'b00; ld_uns = 1'b0;
    @(negedge clk);
    checks++; if (ld_data !== 32'hFFFFFF80) begin errs++; $display("FAIL ext_lb: got %h want ffffff80", ld_data); end
    ld_uns = 1'b1;
    #1;
    checks++; if (ld_data !== 32'h00000080) begin errs++; $display("FAIL ext_lbu: got %h want 00000080", ld_data); end
    ld_req = 1'b0;
    store(32'h40, 32'h00009234, 2'b01);
    drain_out();
    tick();
    ld_req = 1'b1; ld_snb = 2'b01; ld_uns = 1'b0;
    @(negedge clk);
    checks++; if (ld_data !== 32'hFFFF9234) begin errs++; $display("FAIL ext_lh: got %h want ffff9234", ld_data); end
    ld_uns = 1'b1;
    #1;
    checks++; if (ld_data !== 32'h00009234) begin errs++; $display("FAIL ext_lhu: got %h want 00009234", ld_data); end
    ld_req = 1'b0;
    tick();
    st_valid = 1'b1; st_addr = 32'h40; st_data = 32'hFFFFFFFF; st_snb = 2'b11;
    tick();
    st_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_we !== 1'b1 || mem_snb !== 2'b11)
      begin errs++; $display("FAIL noop_store_drain: got we=%b snb=%b want 1 11", mem_we, mem_snb); end
    tick();
    ld_req = 1'b1; ld_snb = 2'b10; ld_uns = 1'b0;
    @(negedge clk);
    checks++; if (ld_data !== 32'h00009234 || empty !== 1'b1)
      begin errs++; $display("FAIL noop_store_mem: got data=%h empty=%b want 00009234 1", ld_data, empty); end
    ld_req = 1'b0;
  endtask

  task automatic test_reset_mid;
    tick();
    ld_req = 1'b1; ld_addr = 32'h80; ld_snb = 2'b10; ld_uns = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1; st_addr = 32'hA0 + 32'(4 * i); st_data = 32'hA5A50000 + 32'(i); st_snb = 2'b10;
      tick();
    end
    st_valid = 1'b0; ld_req = 1'b0;
    base = wr_cnt;
    @(negedge clk);
    checks++; if (mem_we !== 1'b1 || mem_a !== 32'hA0)
      begin errs++; $display("FAIL rmid_first_drain: got we=%b a=%h want 1 a0", mem_we, mem_a); end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin errs++; $display("FAIL rmid_we_in_reset: got %b want 0", mem_we); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (empty !== 1'b1 || st_ready !== 1'b1 || mem_we !== 1'b0)
      begin errs++; $display("FAIL rmid_cleared: got empty=%b ready=%b we=%b want 1 1 0", empty, st_ready, mem_we); end
    ld_req = 1'b1; ld_addr = 32'hA4;
    #1;
    checks++; if (ld_stall !== 1'b0 || ld_data !== 32'h0)
      begin errs++; $display("FAIL rmid_discarded: got stall=%b data=%h want 0 0", ld_stall, ld_data); end
    ld_addr = 32'hA0;
    #1;
    checks++; if (ld_data !== 32'hA5A50000) begin errs++; $display("FAIL rmid_retired: got %h want a5a50000", ld_data); end
    ld_req = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (wr_cnt != base + 1) begin errs++; $display("FAIL rmid_write_count: got %0d want %0d", wr_cnt - base, 1); end
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_snb = 2'b00;
    ld_req = 1'b0; ld_addr = '0; ld_snb = 2'b00; ld_uns = 1'b0;
    test_reset();
    test_store_word();
    test_fill();
    test_back_to_back();
    test_overlap();
    test_boundary();
    test_extend();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1);
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- FIFO store buffer between the single-cycle core's load/store path and the byte-addressed data memory.
- Accepts stores from the core and retires them to memory one per cycle, in cycles with no load.
- Stalls loads that overlap a pending store.
- Sign- or zero-extends load data returned by the memory.

Parameters:
DEPTH, 4, number of store entries; power of two, 2..16
ADDR_W, 32, address width on core and memory sides

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
st_valid  input  1  core presents a store
st_ready  output  1  buffer can accept a store this cycle
st_addr  input  ADDR_W  store byte address
st_data  input  32  store data, low bytes significant for sub-word stores
st_snb  input  2  store size: 00 byte, 01 half, 10 word, 11 no-op
ld_req  input  1  core performs a load this cycle
ld_addr  input  ADDR_W  load byte address
ld_snb  input  2  load size, same encoding as st_snb
ld_uns  input  1  1 = zero-extend, 0 = sign-extend
ld_stall  output  1  load not serviced this cycle; core must hold
ld_data  output  32  extended load result, valid when ld_req=1 and ld_stall=0
mem_we  output  1  memory write enable
mem_a  output  ADDR_W  memory address, shared by reads and writes
mem_wd  output  32  memory write data
mem_snb  output  2  memory access size
mem_rd  input  32  memory combinational read data (bytes A..A+3)
empty  output  1  no pending stores

Behaviour:
- Reset (synchronous, active-high) state:
  - Write pointer, read pointer and count = 0.
  - empty=1, st_ready=1, mem_we=0, ld_stall=0.
  - Reset mid-operation discards all pending entries. Nothing is written in or after the reset cycle.
- Entry contents: {addr, data, snb}.
- Enqueue:
  - Occurs on a clk edge when st_valid & st_ready.
  - st_ready = (count < DEPTH). It depends only on registered count, with no combinational path from ld_req or drain.
- Drain condition: count>0 and (ld_req=0 or ld_stall=1).
  - When true: mem_we=1; mem_a, mem_wd and mem_snb come from the head entry.
  - The read pointer advances on the edge.
  - The head entry is written by data_mem on that same edge.
- Load path:
  - When ld_req=1, mem_a=ld_addr and mem_snb=ld_snb, unless ld_stall=1, in which case the drain owns the bus.
  - When neither a load nor a drain is active: mem_we=0 and mem_a=0.
- Overlap:
  - Byte count n = 1, 2, 4 or 0 for snb 00, 01, 10, 11.
  - Overlap with a valid entry e: (ld_addr < e.addr+e.n) and (e.addr < ld_addr+ld_n).
  - Computed in ADDR_W+1 bits, with no wrap-around.
  - Entries with n=0 never overlap.
- ld_stall = ld_req and (any valid entry overlaps).
  - Combinational; no forwarding.
  - Stalled cycles drain the head, so the stall clears within at most count cycles.
- Simultaneous events:
  - Enqueue and drain in the same cycle leave count unchanged.
  - No empty-bypass: a store accepted at edge k is written no earlier than edge k+1.
  - A store enqueued in the same cycle as a load is not checked against that load.
- Pointer wrap: pointers are log2(DEPTH) bits, wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Load extension, from mem_rd:
  - Byte: bits [7:0], extended from bit 7.
  - Half: bits [15:0], extended from bit 15.
  - Word: unchanged.
  - snb 11: returns 0.
  - ld_uns selects zero-extension over sign-extension.
- A store with snb=11 is accepted and drained with mem_snb=11; memory performs no write.
- empty = (count==0).
- Ordering: stores retire strictly FIFO.

Test Plan:
- Reset then idle: after rst high 2 cycles -> empty=1, st_ready=1, mem_we=0; no memory writes.
- Store sw 0xDEADBEEF @0x10 with ld_req=0 -> next cycle mem_we=1, mem_a=0x10, mem_snb=10; bytes 0x10..0x13 = EF,BE,AD,DE; empty=1 after.
- Fill with ld_req held 1 at non-overlapping addr 0x80 -> st_ready=0 after DEPTH stores, mem_we stays 0. Drop ld_req -> DEPTH consecutive writes in enqueue order, then st_ready=1.
- Overlap stall: pending sb 0x5A @0x21, load lw @0x20 -> ld_stall=1 for one cycle while the entry drains. Then ld_stall=0, ld_data=0x00005A00 given prior zero memory.
- Extension: memory 0x40 = 0x80, lb -> ld_data=0xFFFFFF80. lbu -> 0x00000080. lh with bytes 0x40/0x41 = 0x34/0x92 -> 0xFFFF9234.
- Reset mid-drain: 3 pending entries, rst asserted -> no mem_we from that cycle on; count=0; subsequent load at those addresses returns old memory contents.
